// File: rtl/lsu_unit.sv
// lsu_unit: executes one load/store at a time against the memory controller and
// broadcasts extended load results; rolled-back loads finish on the bus but never report.
module lsu_unit #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ROB_ID_W = 5
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                en_signal_from_lsb,
    input  logic [5:0]          inst_name_from_lsb,
    input  logic [ADDR_W-1:0]   mem_addr_from_lsb,
    input  logic [DATA_W-1:0]   store_value_from_lsb,
    input  logic [ROB_ID_W-1:0] rob_id_from_lsb,
    output logic                busy_to_lsb,
    output logic                en_signal_to_mem_ctrl,
    output logic                rw_flag_to_mem_ctrl,
    output logic [ADDR_W-1:0]   addr_to_mem_ctrl,
    output logic [2:0]          len_to_mem_ctrl,
    output logic [DATA_W-1:0]   data_to_mem_ctrl,
    input  logic                done_from_mem_ctrl,
    input  logic [DATA_W-1:0]   data_from_mem_ctrl,
    output logic                valid_to_exe,
    output logic [DATA_W-1:0]   result_to_exe,
    output logic [ROB_ID_W-1:0] rob_id_to_exe,
    input  logic                rollback_flag_from_rob
);
    localparam logic [5:0] LB = 6'd11, LH = 6'd12, LBU = 6'd14, LHU = 6'd15;
    localparam logic [5:0] SB = 6'd16, SH = 6'd17;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t state, state_nx;

    logic [5:0]          op;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   value_q;
    logic [ROB_ID_W-1:0] rob_q;
    logic                kill;
    logic                is_load;
    logic                accept;
    logic [2:0]          len_nx;
    logic [DATA_W-1:0]   ext;

    assign busy_to_lsb = state != IDLE || en_signal_from_lsb;

    always_comb begin
        is_load = op <= LHU;
        // a load flushed in its issue cycle is simply never taken
        accept = en_signal_from_lsb && !(rollback_flag_from_rob && inst_name_from_lsb <= LHU);
        state_nx = state;
        if (state == IDLE && accept) state_nx = REQ;
        if (state == REQ) state_nx = WAIT;
        if (state == WAIT && done_from_mem_ctrl) state_nx = IDLE;
        len_nx = (op == LB || op == LBU || op == SB) ? 3'd1 :
                 (op == LH || op == LHU || op == SH) ? 3'd2 : 3'd4;
        ext = op == LB  ? {{(DATA_W-8){data_from_mem_ctrl[7]}}, data_from_mem_ctrl[7:0]} :
              op == LBU ? {{(DATA_W-8){1'b0}}, data_from_mem_ctrl[7:0]} :
              op == LH  ? {{(DATA_W-16){data_from_mem_ctrl[15]}}, data_from_mem_ctrl[15:0]} :
              op == LHU ? {{(DATA_W-16){1'b0}}, data_from_mem_ctrl[15:0]} :
                          data_from_mem_ctrl;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) state <= IDLE;
        else if (rdy_in) state <= state_nx;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            en_signal_to_mem_ctrl <= 1'b0;
            rw_flag_to_mem_ctrl   <= 1'b0;
            addr_to_mem_ctrl      <= '0;
            len_to_mem_ctrl       <= 3'd0;
            data_to_mem_ctrl      <= '0;
            valid_to_exe          <= 1'b0;
            result_to_exe         <= '0;
            rob_id_to_exe         <= '0;
            kill                  <= 1'b0;
            op                    <= 6'd0;
            addr_q                <= '0;
            value_q               <= '0;
            rob_q                 <= '0;
        end else if (rdy_in) begin
            valid_to_exe <= 1'b0;
            if (state == IDLE && accept) begin
                op      <= inst_name_from_lsb;
                addr_q  <= mem_addr_from_lsb;
                value_q <= store_value_from_lsb;
                rob_q   <= rob_id_from_lsb;
            end
            if (state == REQ) begin
                en_signal_to_mem_ctrl <= 1'b1;
                rw_flag_to_mem_ctrl   <= op >= SB;
                addr_to_mem_ctrl      <= addr_q;
                len_to_mem_ctrl       <= len_nx;
                data_to_mem_ctrl      <= value_q;
            end
            if (state != IDLE && is_load && rollback_flag_from_rob) kill <= 1'b1;
            if (state == WAIT && done_from_mem_ctrl) begin
                en_signal_to_mem_ctrl <= 1'b0;
                kill                  <= 1'b0;
                if (is_load && !kill && !rollback_flag_from_rob) begin
                    valid_to_exe  <= 1'b1;
                    result_to_exe <= ext;
                    rob_id_to_exe <= rob_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_lsu_unit.sv
// tb_lsu_unit: table-driven load/store vectors with a result scoreboard, plus
// hand-written rollback, reset and stall sequences.
module tb_lsu_unit;
    localparam logic [5:0] LB = 6'd11, LH = 6'd12, LW = 6'd13, LBU = 6'd14, LHU = 6'd15;
    localparam logic [5:0] SB = 6'd16, SH = 6'd17, SW = 6'd18;

    logic        clk_in = 0, rst_in = 0, rdy_in = 1;
    logic        en_signal_from_lsb = 0, done_from_mem_ctrl = 0, rollback_flag_from_rob = 0;
    logic [5:0]  inst_name_from_lsb = 0;
    logic [31:0] mem_addr_from_lsb = 0, store_value_from_lsb = 0, data_from_mem_ctrl = 0;
    logic [4:0]  rob_id_from_lsb = 0;
    logic        busy_to_lsb, en_signal_to_mem_ctrl, rw_flag_to_mem_ctrl, valid_to_exe;
    logic [31:0] addr_to_mem_ctrl, data_to_mem_ctrl, result_to_exe;
    logic [2:0]  len_to_mem_ctrl;
    logic [4:0]  rob_id_to_exe;

    lsu_unit dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .en_signal_from_lsb(en_signal_from_lsb), .inst_name_from_lsb(inst_name_from_lsb),
        .mem_addr_from_lsb(mem_addr_from_lsb), .store_value_from_lsb(store_value_from_lsb),
        .rob_id_from_lsb(rob_id_from_lsb), .busy_to_lsb(busy_to_lsb),
        .en_signal_to_mem_ctrl(en_signal_to_mem_ctrl), .rw_flag_to_mem_ctrl(rw_flag_to_mem_ctrl),
        .addr_to_mem_ctrl(addr_to_mem_ctrl), .len_to_mem_ctrl(len_to_mem_ctrl),
        .data_to_mem_ctrl(data_to_mem_ctrl), .done_from_mem_ctrl(done_from_mem_ctrl),
        .data_from_mem_ctrl(data_from_mem_ctrl), .valid_to_exe(valid_to_exe),
        .result_to_exe(result_to_exe), .rob_id_to_exe(rob_id_to_exe),
        .rollback_flag_from_rob(rollback_flag_from_rob)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] val;
        logic [4:0]  rob;
        logic [31:0] mdata;
        int          dly;
        logic [2:0]  len;
        logic        rw;
        logic [31:0] res;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rob;
    } exp_t;

    vec_t vecs[11];
    exp_t sb_q[$];
    int   checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // every output is observed at the falling edge; any result pulse must match the scoreboard
    task automatic cycle();
        exp_t e;
        @(negedge clk_in);
        if (valid_to_exe === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got result %h rob %0d expected no pulse", result_to_exe, rob_id_to_exe);
            end else begin
                e = sb_q.pop_front();
                chk("result", result_to_exe, e.res);
                chk("rob_id", {27'd0, rob_id_to_exe}, {27'd0, e.rob});
            end
        end
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] val,
                         input logic [4:0] rob, input logic rb);
        chk("busy_before_issue", busy_to_lsb, 0);
        inst_name_from_lsb = op;
        mem_addr_from_lsb = addr;
        store_value_from_lsb = val;
        rob_id_from_lsb = rob;
        rollback_flag_from_rob = rb;
        en_signal_from_lsb = 1;
        #1 chk("busy_on_issue", busy_to_lsb, 1);
        cycle();
        en_signal_from_lsb = 0;
        rollback_flag_from_rob = 0;
    endtask

    task automatic wait_req();
        logic seen = 0;
        for (int i = 0; i < 4 && !seen; i++) begin
            cycle();
            seen = en_signal_to_mem_ctrl;
        end
        chk("req_seen", seen, 1);
    endtask

    task automatic finish(input logic [31:0] mdata, input logic rb);
        done_from_mem_ctrl = 1;
        data_from_mem_ctrl = mdata;
        rollback_flag_from_rob = rb;
        cycle();
        done_from_mem_ctrl = 0;
        rollback_flag_from_rob = 0;
        chk("en_drop", en_signal_to_mem_ctrl, 0);
        chk("busy_after_done", busy_to_lsb, 0);
        cycle();
        chk("no_pending_result", sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{LW,  32'h100, 32'h0,        5'd3,  32'hDEADBEEF, 3, 3'd4, 1'b0, 32'hDEADBEEF};
        vecs[1]  = '{LB,  32'h20,  32'h0,        5'd4,  32'h00000080, 1, 3'd1, 1'b0, 32'hFFFFFF80};
        vecs[2]  = '{LBU, 32'h20,  32'h0,        5'd5,  32'h00000080, 1, 3'd1, 1'b0, 32'h00000080};
        vecs[3]  = '{LH,  32'h22,  32'h0,        5'd6,  32'h00008001, 2, 3'd2, 1'b0, 32'hFFFF8001};
        vecs[4]  = '{LHU, 32'h22,  32'h0,        5'd7,  32'h00008001, 0, 3'd2, 1'b0, 32'h00008001};
        vecs[5]  = '{SH,  32'h30,  32'h12345678, 5'd8,  32'h0,        2, 3'd2, 1'b1, 32'h0};
        vecs[6]  = '{SB,  32'h31,  32'hAABBCCDD, 5'd9,  32'h0,        1, 3'd1, 1'b1, 32'h0};
        vecs[7]  = '{SW,  32'h37,  32'hCAFEBABE, 5'd10, 32'h0,        0, 3'd4, 1'b1, 32'h0};
        vecs[8]  = '{LB,  32'h41,  32'h0,        5'd11, 32'h1234567F, 1, 3'd1, 1'b0, 32'h0000007F};
        vecs[9]  = '{LH,  32'h42,  32'h0,        5'd12, 32'hFFFF7FFF, 1, 3'd2, 1'b0, 32'h00007FFF};
        vecs[10] = '{LW,  32'h44,  32'h0,        5'd31, 32'h80000001, 0, 3'd4, 1'b0, 32'h80000001};

        rst_in = 0;
        cycle();
        cycle();
        chk("rst_en", en_signal_to_mem_ctrl, 0);
        chk("rst_valid", valid_to_exe, 0);
        chk("rst_busy", busy_to_lsb, 0);
        chk("rst_len", len_to_mem_ctrl, 0);
        rst_in = 1;
        cycle();

        foreach (vecs[k]) begin
            if (!vecs[k].rw) sb_q.push_back('{vecs[k].res, vecs[k].rob});
            issue(vecs[k].op, vecs[k].addr, vecs[k].val, vecs[k].rob, 0);
            wait_req();
            chk("rw", rw_flag_to_mem_ctrl, vecs[k].rw);
            chk("len", len_to_mem_ctrl, vecs[k].len);
            chk("addr", addr_to_mem_ctrl, vecs[k].addr);
            chk("data", data_to_mem_ctrl, vecs[k].val);
            for (int d = 0; d < vecs[k].dly; d++) begin
                cycle();
                chk("hold_en", en_signal_to_mem_ctrl, 1);
                chk("hold_busy", busy_to_lsb, 1);
                chk("hold_addr", addr_to_mem_ctrl, vecs[k].addr);
                chk("hold_data", data_to_mem_ctrl, vecs[k].val);
            end
            finish(vecs[k].mdata, 0);
        end

        // load flushed while waiting: transaction completes silently
        issue(LW, 32'h50, 0, 5'd13, 0);
        wait_req();
        rollback_flag_from_rob = 1;
        cycle();
        rollback_flag_from_rob = 0;
        cycle();
        chk("kill_hold_en", en_signal_to_mem_ctrl, 1);
        cycle();
        finish(32'h11111111, 0);
        chk("kill_no_valid", valid_to_exe, 0);
        sb_q.push_back('{32'h22222222, 5'd14});
        issue(LW, 32'h54, 0, 5'd14, 0);
        wait_req();
        finish(32'h22222222, 0);

        // load flushed in its issue cycle is dropped
        issue(LW, 32'h58, 0, 5'd15, 1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("drop_en", en_signal_to_mem_ctrl, 0);
            chk("drop_busy", busy_to_lsb, 0);
        end

        // store flushed in its issue cycle still goes out
        issue(SW, 32'h5C, 32'h0BADF00D, 5'd16, 1);
        wait_req();
        chk("rb_store_rw", rw_flag_to_mem_ctrl, 1);
        chk("rb_store_data", data_to_mem_ctrl, 32'h0BADF00D);
        finish(0, 0);

        // flush coinciding with completion
        issue(LHU, 32'h60, 0, 5'd17, 0);
        wait_req();
        finish(32'h0000FFFF, 1);

        // reset mid-wait abandons the request and ignores a late done
        issue(LW, 32'h64, 32'h77, 5'd18, 0);
        wait_req();
        rst_in = 0;
        cycle();
        chk("rstw_en", en_signal_to_mem_ctrl, 0);
        chk("rstw_addr", addr_to_mem_ctrl, 0);
        chk("rstw_data", data_to_mem_ctrl, 0);
        chk("rstw_result", result_to_exe, 0);
        chk("rstw_rob", rob_id_to_exe, 0);
        chk("rstw_busy", busy_to_lsb, 0);
        rst_in = 1;
        done_from_mem_ctrl = 1;
        data_from_mem_ctrl = 32'h99999999;
        cycle();
        done_from_mem_ctrl = 0;
        cycle();
        chk("late_done_valid", valid_to_exe, 0);
        chk("late_done_en", en_signal_to_mem_ctrl, 0);

        // stall mid-wait freezes everything, completion resumes afterwards
        sb_q.push_back('{32'hFFFFFFF0, 5'd19});
        issue(LB, 32'h200, 0, 5'd19, 0);
        wait_req();
        rdy_in = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_en", en_signal_to_mem_ctrl, 1);
            chk("stall_addr", addr_to_mem_ctrl, 32'h200);
            chk("stall_len", len_to_mem_ctrl, 1);
        end
        rdy_in = 1;
        cycle();
        finish(32'h000000F0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
